// File: rtl/ftdi_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the FTDI write FIFO between N_REQ byte sources,
// with a stall watchdog. Define FTDI_ARB_HEADER_EN to prefix each packet with a {4'hA,2'b00,id} byte.
module ftdi_tx_arbiter #(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               res_n,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         fifo_din,
    output logic               fifo_wr_en,
    input  logic               fifo_full,
    output logic [1:0]         grant_id,
    output logic               busy,
    output logic               timeout_pulse,
    output logic [7:0]         timeout_count,
    input  logic               timeout_clear
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [1:0]  grant_id_r;
    logic [1:0]  search_base_r;
    logic [1:0]  pick_s;
    logic        any_valid_s;
    logic        sel_valid_s;
    logic        sel_last_s;
    logic [7:0]  sel_data_s;
    logic        xfer_s;
    logic        last_xfer_s;
    logic        wd_expire_s;
    logic        hdr_done_s;
    logic [15:0] wd_r;
    logic [7:0]  timeout_count_r;
    logic        timeout_pulse_r;
    logic        busy_r;

    function automatic logic [1:0] next_idx(input logic [1:0] g);
        if (g == 2'(N_REQ - 1)) begin
            return 2'd0;
        end else begin
            return g + 2'd1;
        end
    endfunction

    // Route the granted requester's valid/last/data onto shared select signals
    always_comb begin
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        sel_data_s  = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id_r == 2'(i)) begin
                sel_valid_s = req_valid[i];
                sel_last_s  = req_last[i];
                sel_data_s  = req_data[8*i +: 8];
            end else begin
                sel_valid_s = sel_valid_s;
            end
        end
    end

    // Round-robin pick: smallest wrap distance from the search base among valid requesters
    always_comb begin
        int dist_s;
        int best_s;
        any_valid_s = 1'b0;
        pick_s      = 2'd0;
        dist_s      = 0;
        best_s      = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
            dist_s = (i + N_REQ - int'(search_base_r)) % N_REQ;
            if (req_valid[i] && (dist_s < best_s)) begin
                best_s      = dist_s;
                pick_s      = 2'(i);
                any_valid_s = 1'b1;
            end else begin
                any_valid_s = any_valid_s;
            end
        end
    end

    assign xfer_s      = (state_r == ST_STREAM) && sel_valid_s && !fifo_full;
    assign last_xfer_s = xfer_s && sel_last_s;
    // Only cycles where the owner offers nothing count; back-pressure stalls never expire the grant
    assign wd_expire_s = (state_r == ST_STREAM) && !sel_valid_s && (wd_r == 16'(TIMEOUT - 1));
    assign hdr_done_s  = (state_r == ST_HEADER) && !fifo_full;

    // State register
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_valid_s) begin
`ifdef FTDI_ARB_HEADER_EN
                    state_nxt_s = ST_HEADER;
`else
                    state_nxt_s = ST_STREAM;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HEADER: begin
                if (hdr_done_s) begin
                    state_nxt_s = ST_STREAM;
                end else begin
                    state_nxt_s = ST_HEADER;
                end
            end
            ST_STREAM: begin
                if (last_xfer_s || wd_expire_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output logic: handshake and FIFO write port follow the grant in the same cycle
    always_comb begin
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        fifo_din   = 8'h00;
        case (state_r)
            ST_STREAM: begin
                for (int i = 0; i < N_REQ; i++) begin
                    req_ready[i] = (grant_id_r == 2'(i)) ? !fifo_full : 1'b0;
                end
                fifo_wr_en = sel_valid_s && !fifo_full;
                fifo_din   = sel_data_s;
            end
            ST_HEADER: begin
`ifdef FTDI_ARB_HEADER_EN
                fifo_wr_en = !fifo_full;
                fifo_din   = {4'hA, 2'b00, grant_id_r};
`else
                fifo_wr_en = 1'b0;
`endif
            end
            ST_IDLE: fifo_wr_en = 1'b0;
            default: fifo_wr_en = 1'b0;
        endcase
    end

    // Grant, round-robin base, watchdog and timeout statistics
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            grant_id_r      <= 2'd0;
            search_base_r   <= 2'd0;
            wd_r            <= 16'd0;
            timeout_pulse_r <= 1'b0;
            timeout_count_r <= 8'd0;
            busy_r          <= 1'b0;
        end else begin
            busy_r          <= (state_nxt_s != ST_IDLE);
            timeout_pulse_r <= wd_expire_s;
            if ((state_r == ST_IDLE) && any_valid_s) begin
                grant_id_r <= pick_s;
            end
            if (last_xfer_s || wd_expire_s) begin
                search_base_r <= next_idx(grant_id_r);
            end
            if ((state_r != ST_STREAM) || xfer_s) begin
                wd_r <= 16'd0;
            end else if (!sel_valid_s) begin
                wd_r <= wd_r + 16'd1;
            end
            if (timeout_clear) begin
                timeout_count_r <= 8'd0;
            end else if (wd_expire_s && (timeout_count_r != 8'hFF)) begin
                timeout_count_r <= timeout_count_r + 8'd1;
            end
        end
    end

    assign grant_id      = grant_id_r;
    assign busy          = busy_r;
    assign timeout_pulse = timeout_pulse_r;
    assign timeout_count = timeout_count_r;

endmodule
